// File: rtl/hop_cnt_rr_arbiter.sv
// Packet-locking output-port arbiter: highest hop count wins, round-robin breaks ties,
// saturated age counters force starving inputs through; grant held from head to tail flit.
module hop_cnt_rr_arbiter #(
    parameter int IN_N      = 5,
    parameter int HOP_CNT_W = 3,
    parameter int AGE_W     = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [IN_N-1:0]           req_i,
    input  logic [IN_N*HOP_CNT_W-1:0] hop_cnt_i,
    input  logic [IN_N-1:0]           tail_i,
    input  logic                      ack_i,
    output logic [IN_N-1:0]           grant_o,
    output logic [$clog2(IN_N)-1:0]   grant_idx_o,
    output logic                      grant_vld_o,
    output logic                      starved_o
);
    localparam int IDX_W = $clog2(IN_N);
    localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN_N - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t                r_state;
    logic [IN_N-1:0]       r_grant;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_starved;
    logic [IDX_W-1:0]      r_ptr;
    logic [AGE_W-1:0]      r_age [IN_N];

    state_t                w_state_nxt;
    logic [IN_N-1:0]       w_grant_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_starved_nxt;
    logic [AGE_W-1:0]      w_age_nxt [IN_N];

    logic                  w_locked;
    logic                  w_req_w;
    logic                  w_release;
    logic                  w_event;
    logic [IN_N-1:0]       w_mreq;
    logic [IDX_W-1:0]      w_ptr;
    logic [IN_N-1:0]       w_aged;
    logic [IN_N-1:0]       w_top;
    logic [IN_N-1:0]       w_cand;
    logic                  w_any_aged;
    logic [HOP_CNT_W-1:0]  w_max_hop;
    logic                  w_found;
    logic [IDX_W-1:0]      w_win;

    // Release detection; the released input is masked and the pointer advanced for the same-cycle event
    always_comb begin
        w_locked  = (r_state == ST_LOCKED);
        w_req_w   = req_i[r_idx];
        w_release = w_locked & ((ack_i & w_req_w & tail_i[r_idx]) | ~w_req_w);
        w_event   = w_locked ? w_release : (|req_i);
        w_mreq    = req_i;
        w_ptr     = r_ptr;
        if (w_release) begin
            w_mreq[r_idx] = 1'b0;
            w_ptr         = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            w_ptr         = r_ptr;
        end
    end

    // Candidate set (starved inputs override hop priority) and round-robin pick from w_ptr
    always_comb begin
        w_aged    = '0;
        w_top     = '0;
        w_max_hop = '0;
        w_found   = 1'b0;
        w_win     = '0;
        for (int k = 0; k < IN_N; k++) begin
            w_aged[k] = w_mreq[k] & (r_age[k] == AGE_MAX);
            if (w_mreq[k] && (hop_cnt_i[k*HOP_CNT_W +: HOP_CNT_W] > w_max_hop)) begin
                w_max_hop = hop_cnt_i[k*HOP_CNT_W +: HOP_CNT_W];
            end else begin
                w_max_hop = w_max_hop;
            end
        end
        for (int k = 0; k < IN_N; k++) begin
            w_top[k] = w_mreq[k] & (hop_cnt_i[k*HOP_CNT_W +: HOP_CNT_W] == w_max_hop);
        end
        w_any_aged = |w_aged;
        w_cand     = w_any_aged ? w_aged : w_top;
        for (int i = 0; i < IN_N; i++) begin
            int j;
            j = int'(w_ptr) + i;
            if (j >= IN_N) begin
                j = j - IN_N;
            end else begin
                j = j;
            end
            if (!w_found && w_cand[j]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(j);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state: grant/lock on an event, idle when nothing survives the release mask; age bookkeeping
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_idx_nxt     = r_idx;
        w_starved_nxt = r_starved;
        if (w_event && (|w_mreq)) begin
            w_state_nxt        = ST_LOCKED;
            w_grant_nxt        = '0;
            w_grant_nxt[w_win] = 1'b1;
            w_idx_nxt          = w_win;
            w_starved_nxt      = w_any_aged;
        end else if (w_event) begin
            w_state_nxt   = ST_IDLE;
            w_grant_nxt   = '0;
            w_idx_nxt     = '0;
            w_starved_nxt = 1'b0;
        end else begin
            w_state_nxt   = r_state;
        end
        for (int k = 0; k < IN_N; k++) begin
            if (!w_locked && !req_i[k]) begin
                w_age_nxt[k] = '0;
            end else if (w_event && w_mreq[k]) begin
                if (IDX_W'(k) == w_win) begin
                    w_age_nxt[k] = '0;
                end else if (r_age[k] != AGE_MAX) begin
                    w_age_nxt[k] = r_age[k] + AGE_W'(1);
                end else begin
                    w_age_nxt[k] = r_age[k];
                end
            end else begin
                w_age_nxt[k] = r_age[k];
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_idx     <= '0;
            r_starved <= 1'b0;
            r_ptr     <= '0;
            for (int k = 0; k < IN_N; k++) r_age[k] <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_idx     <= w_idx_nxt;
            r_starved <= w_starved_nxt;
            r_ptr     <= w_ptr;
            for (int k = 0; k < IN_N; k++) r_age[k] <= w_age_nxt[k];
        end
    end

    // Outputs driven straight from registers
    always_comb begin
        grant_o     = r_grant;
        grant_idx_o = r_idx;
        grant_vld_o = (r_state == ST_LOCKED);
        starved_o   = r_starved;
    end
endmodule

// File: tb/tb_hop_cnt_rr_arbiter.sv
// Scoreboard bench: a behavioural model predicts each cycle's registered outputs,
// a monitor compares them one cycle later.
module tb_hop_cnt_rr_arbiter;
    localparam int N    = 5;
    localparam int H    = 3;
    localparam int A    = 2;
    localparam int IW   = $clog2(N);
    localparam int AMAX = (1 << A) - 1;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic [N-1:0]    req_i = '0;
    logic [N*H-1:0]  hop_cnt_i = '0;
    logic [N-1:0]    tail_i = '0;
    logic            ack_i = 1'b0;
    logic [N-1:0]    grant_o;
    logic [IW-1:0]   grant_idx_o;
    logic            grant_vld_o;
    logic            starved_o;

    hop_cnt_rr_arbiter #(.IN_N(N), .HOP_CNT_W(H), .AGE_W(A)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .hop_cnt_i(hop_cnt_i),
        .tail_i(tail_i), .ack_i(ack_i), .grant_o(grant_o), .grant_idx_o(grant_idx_o),
        .grant_vld_o(grant_vld_o), .starved_o(starved_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  g;
        logic [IW-1:0] idx;
        logic          vld;
        logic          st;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    // Reference state: owner of the output port, pointer, ages
    bit   m_locked = 1'b0;
    int   m_w = 0;
    int   m_ptr = 0;
    bit   m_starved = 1'b0;
    int   m_age[N];

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int hop_of(input logic [N*H-1:0] hop, input int k);
        int v = 0;
        for (int b = 0; b < H; b++) if (hop[k*H+b]) v += (1 << b);
        return v;
    endfunction

    task automatic model_step(input logic rst, input logic [N-1:0] req,
                              input logic [N*H-1:0] hop, input logic [N-1:0] tail, input logic ack);
        exp_t e;
        if (rst) begin
            m_locked = 0; m_w = 0; m_ptr = 0; m_starved = 0;
            for (int k = 0; k < N; k++) m_age[k] = 0;
        end else begin
            bit rel = 0;
            bit ev;
            bit part[N];
            int cands[$];
            bit st;
            for (int k = 0; k < N; k++) part[k] = req[k];
            if (m_locked) begin
                if (!req[m_w]) rel = 1;
                else if (ack && tail[m_w]) rel = 1;
                if (rel) begin
                    m_ptr = (m_w + 1) % N;
                    part[m_w] = 0;
                end
            end
            ev = m_locked ? rel : (req != '0);
            if (!m_locked) for (int k = 0; k < N; k++) if (!req[k]) m_age[k] = 0;
            if (ev) begin
                for (int k = 0; k < N; k++) if (part[k] && m_age[k] == AMAX) cands.push_back(k);
                st = (cands.size() > 0);
                if (!st) begin
                    int mx = -1;
                    for (int k = 0; k < N; k++) if (part[k] && hop_of(hop, k) > mx) mx = hop_of(hop, k);
                    for (int k = 0; k < N; k++) if (part[k] && hop_of(hop, k) == mx) cands.push_back(k);
                end
                if (cands.size() == 0) begin
                    m_locked = 0; m_w = 0; m_starved = 0;
                end else begin
                    int best = cands[0];
                    int bestd = N;
                    foreach (cands[c]) begin
                        int d = (cands[c] - m_ptr + N) % N;
                        if (d < bestd) begin bestd = d; best = cands[c]; end
                    end
                    for (int k = 0; k < N; k++)
                        if (part[k]) m_age[k] = (k == best) ? 0 : ((m_age[k] < AMAX) ? m_age[k] + 1 : AMAX);
                    m_locked = 1; m_w = best; m_starved = st;
                end
            end
        end
        e.g   = m_locked ? N'(1 << m_w) : '0;
        e.idx = m_locked ? IW'(m_w) : '0;
        e.vld = m_locked;
        e.st  = m_locked && m_starved;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic rst, input logic [N-1:0] req, input logic [N*H-1:0] hop,
                       input logic [N-1:0] tail, input logic ack);
        @(negedge clk);
        rst_i = rst; req_i = req; hop_cnt_i = hop; tail_i = tail; ack_i = ack;
        model_step(rst, req, hop, tail, ack);
    endtask

    function automatic logic [N*H-1:0] hops(input int h0, input int h1, input int h2, input int h3, input int h4);
        logic [N*H-1:0] v;
        v[0*H +: H] = H'(h0); v[1*H +: H] = H'(h1); v[2*H +: H] = H'(h2);
        v[3*H +: H] = H'(h3); v[4*H +: H] = H'(h4);
        return v;
    endfunction

    // Monitor: registered outputs are compared just after each active edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("grant_o",     int'(grant_o),     int'(e.g));
            chk("grant_idx_o", int'(grant_idx_o), int'(e.idx));
            chk("grant_vld_o", int'(grant_vld_o), int'(e.vld));
            chk("starved_o",   int'(starved_o),   int'(e.st));
        end
    end

    initial begin
        logic [N-1:0]   rq;
        logic [31:0]    r;
        for (int k = 0; k < N; k++) m_age[k] = 0;
        repeat (3) cyc(1'b1, '0, '0, '0, 1'b0);
        // Single request, 3-flit packet
        cyc(1'b0, 5'b00100, hops(0, 0, 2, 0, 0), 5'b00000, 1'b1);
        cyc(1'b0, 5'b00100, hops(0, 0, 2, 0, 0), 5'b00000, 1'b1);
        cyc(1'b0, 5'b00100, hops(0, 0, 2, 0, 0), 5'b00000, 1'b1);
        cyc(1'b0, 5'b00100, hops(0, 0, 2, 0, 0), 5'b00100, 1'b1);
        cyc(1'b0, 5'b00000, '0, '0, 1'b1);
        cyc(1'b0, 5'b00000, '0, '0, 1'b1);
        // Hop priority from rr_ptr=0, then back-to-back to the tied input
        cyc(1'b1, '0, '0, '0, 1'b0);
        cyc(1'b0, 5'b11111, hops(1, 4, 2, 4, 0), 5'b00000, 1'b1);
        cyc(1'b0, 5'b11111, hops(1, 4, 2, 4, 0), 5'b00000, 1'b1);
        cyc(1'b0, 5'b11111, hops(1, 4, 2, 4, 0), 5'b00010, 1'b1);
        cyc(1'b0, 5'b11111, hops(1, 4, 2, 4, 0), 5'b00000, 1'b1);
        // Round-robin tie with single-flit packets
        for (int i = 0; i < 12; i++) cyc(1'b0, 5'b11111, hops(3, 3, 3, 3, 3), 5'b11111, 1'b1);
        // Starvation of a low-hop input
        cyc(1'b1, '0, '0, '0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 5'b11111, hops(0, 7, 7, 7, 7), 5'b11111, 1'b1);
        // Lock and stall, then abort, then reset mid-packet
        cyc(1'b1, '0, '0, '0, 1'b0);
        cyc(1'b0, 5'b00100, hops(0, 0, 1, 0, 0), 5'b00000, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 5'b10100, hops(0, 0, 1, 0, 7), 5'b00000, 1'b0);
        cyc(1'b0, 5'b10100, hops(0, 0, 1, 0, 7), 5'b00100, 1'b1);
        cyc(1'b0, 5'b10100, hops(0, 0, 1, 0, 7), 5'b00000, 1'b0);
        cyc(1'b0, 5'b00110, hops(0, 5, 1, 0, 7), 5'b00000, 1'b0);
        cyc(1'b0, 5'b00110, hops(0, 5, 1, 0, 7), 5'b00000, 1'b1);
        cyc(1'b1, 5'b00110, hops(0, 5, 1, 0, 7), 5'b00000, 1'b1);
        cyc(1'b0, 5'b00000, '0, '0, 1'b0);
        // Randomized traffic with sticky requests, occasional aborts and resets
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) if ($urandom_range(0, 7) == 0) rq[k] = ~rq[k];
            r = $urandom;
            cyc(($urandom_range(0, 249) == 0), rq, r[N*H-1:0], r[N*H +: N], ($urandom_range(0, 3) != 0));
        end
        @(posedge clk);
        #2;
        chk("queue_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/hop_cnt_rr_arbiter.md
# hop_cnt_rr_arbiter

Parametrised, registered, packet-locking output-port arbiter for the mesh switch. Among requesting inputs it grants the one with the highest hop count. Ties are broken by round-robin. Inputs that lose too often are forced through by an age counter. The grant is held for the whole wormhole packet, from head flit to tail flit, and feeds the output multiplexer select.

## Interface
- `IN_N`, default 5: number of competing inputs. Legal range 2..16.
- `HOP_CNT_W`, default 3: width of each hop-count field (unsigned).
- `AGE_W`, default 3: width of each per-input starvation counter. An input is starved when its counter reaches 2^AGE_W-1.

Ports:
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `req_i`, input, IN_N: per-input request (flit valid, routed to this output).
- `hop_cnt_i`, input, IN_N*HOP_CNT_W: hop counts, packed. Input k occupies bits [k*HOP_CNT_W +: HOP_CNT_W].
- `tail_i`, input, IN_N: the flit currently presented on input k is the tail flit.
- `ack_i`, input, 1: downstream accepted the granted flit this cycle.
- `grant_o`, output, IN_N: one-hot grant, registered.
- `grant_idx_o`, output, $clog2(IN_N): binary index of the granted input, registered.
- `grant_vld_o`, output, 1: a grant is active (equals |grant_o).
- `starved_o`, output, 1: the current grant was issued through the starvation path.

## Operation
- There are two states.
  - IDLE: grant_vld_o=0.
  - LOCKED: grant_vld_o=1 and the winner W is held.
- Arbitration event: occurs in IDLE when |req_i=1, and also on a release cycle (see below). The event result is registered, and the FSM enters LOCKED on the next edge.
- Candidate selection during an event:
  - Only inputs with req_i[k]=1 participate. A non-requesting input never wins, whatever its hop count.
  - Any requesting input with age==max forms the candidate set. In that case hop count is ignored and starved_o is set with the grant.
  - Otherwise the candidates are the requesting inputs whose hop count equals the maximum hop count among requesting inputs.
  - Winner: the first candidate at or after rr_ptr, searching upward with wrap modulo IN_N.
- Transfer: a transfer happens when grant_vld_o & ack_i & req_i[W].
- Release happens in either of two cases:
  - A transfer with tail_i[W]=1.
  - req_i[W]=0 while LOCKED. This is a protocol violation, handled as an abort.
- On release:
  - rr_ptr <= (W+1) mod IN_N.
  - Input W is masked out of the same-cycle arbitration event. That event uses the updated pointer value (W+1).
  - If the masked requests are empty, the FSM goes to IDLE and grant_o <= 0.
- Age counters, updated at each arbitration event:
  - The winner's counter clears.
  - Each losing input with req_i=1 increments, saturating at 2^AGE_W-1.
  - In IDLE, an input with req_i=0 clears its counter.
  - Counters are not touched during LOCKED cycles that are not events.
- Single-flit packet: a head flit with tail_i=1 releases on its first transfer.
- ack_i is ignored while grant_vld_o=0.

## Timing
- Reset values: state IDLE, grant_o=0, grant_idx_o=0, grant_vld_o=0, starved_o=0, rr_ptr=0, all age counters 0.
- Reset asserted mid-packet drops the grant at the next edge. No release bookkeeping is performed.
- Latency: a request seen in IDLE at cycle N gives a grant at cycle N+1.
- Back-to-back packets: a tail transfer at cycle N gives the new grant at cycle N+1, with no bubble.
- Outputs are purely registered, with no combinational path from the inputs.
- Hop-count comparison is unsigned and full width. No output depends on comparator-tree depth or on IN_N being 5.

## Test plan
- **Single request.** Reset, then req_i=00100 with hop 2. Required: grant_o=00100 and grant_idx_o=2 at N+1. After a 3-flit packet with ack held high (tail_i[2]=1 on the 3rd flit), grant_vld_o=0 one cycle after the tail.
- **Hop priority.** req_i=11111 with hops {0:1, 1:4, 2:2, 3:4, 4:0} and rr_ptr=0. Required: grant to input 1. After its tail, rr_ptr=2 and the back-to-back grant goes to input 3 with no bubble.
- **Round-robin tie.** All 5 inputs request with hop 3, sending single-flit packets with ack=1 every cycle. Required: grants 0,1,2,3,4,0… on consecutive cycles.
- **Starvation.** Use AGE_W=2. Input 0 requests constantly with hop 0 while inputs 1..4 keep sending hop-7 single-flit packets. Required: input 0 is granted with starved_o=1 at the arbitration event following its 3rd loss, and its age then clears.
- **Lock and stall.** Input 2 is granted with ack_i=0 for 5 cycles while input 4 raises hop 7. Required: grant stays on input 2 until its tail transfer, then moves to input 4.
- **Abort and reset.** Drop req_i[W] mid-packet. Required: release and rr_ptr=W+1. Assert rst_i mid-packet. Required: all outputs 0 at the next edge.
